// File: rtl/ififo_ctrl.sv
// rtl/ififo_ctrl.sv - input FIFO fill/drain controller between SRAM and PE array
//
// Purpose: on start, reads len words from SRAM beginning at base_addr, writes
// each into the input FIFO one cycle later, and pops words toward the PE array
// whenever the FIFO holds data and the array is ready. The SRAM is only read
// while FIFO occupancy plus any pending read stays below 15 entries.
//
// Parameters: bw (bits per lane), row (lanes per word), aw (SRAM address
// width), cw (transfer length width).
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous active-low reset
//   start       in   begin transfer (honoured only when idle)
//   base_addr   in   first SRAM address, sampled with start
//   len         in   word count, sampled with start
//   sram_cen    out  active-low SRAM read enable
//   sram_addr   out  SRAM read address
//   sram_rdata  in   SRAM read data, one cycle after sram_cen low
//   fifo_in     out  FIFO write data
//   fifo_wr     out  FIFO write strobe
//   fifo_full   in   FIFO full flag (checked, never used for control)
//   fifo_ready  in   FIFO non-empty flag
//   fifo_rd     out  FIFO pop strobe toward PE array
//   dn_ready    in   PE array accepts a word this cycle
//   busy        out  transfer in progress
//   done        out  one-cycle completion pulse
//   stall_cnt   out  starved-cycle counter (only with IFIFO_CTRL_PERF_EN)
//
// Build option: define IFIFO_CTRL_PERF_EN to add the stall_cnt port/counter.

module ififo_ctrl #(
   parameter int bw  = 4,
   parameter int row = 8,
   parameter int aw  = 11,
   parameter int cw  = 11
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [aw-1:0]       base_addr,
   input  logic [cw-1:0]       len,
   output logic                sram_cen,
   output logic [aw-1:0]       sram_addr,
   input  logic [bw*row-1:0]   sram_rdata,
   output logic [bw*row-1:0]   fifo_in,
   output logic                fifo_wr,
   input  logic                fifo_full,
   input  logic                fifo_ready,
   output logic                fifo_rd,
   input  logic                dn_ready,
   output logic                busy,
   output logic                done
`ifdef IFIFO_CTRL_PERF_EN
   ,
   output logic [15:0]         stall_cnt
`endif
);

   localparam logic [4:0] OCC_MAX = 5'd15;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [aw-1:0] base_q, base_d;
   logic [cw-1:0] len_q, len_d;
   logic [cw-1:0] issued_q, issued_d;
   logic [cw-1:0] written_q, written_d;
   logic [cw-1:0] drained_q, drained_d;
   logic [4:0]    occ_q, occ_d;
   logic          inflight_q, inflight_d;
   logic          rd_issue;
   logic          active;

`ifdef IFIFO_CTRL_PERF_EN
   logic [15:0]   stall_q, stall_d;
`endif

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      len_d      = len_q;
      issued_d   = issued_q;
      written_d  = written_q;
      drained_d  = drained_q;
      occ_d      = occ_q;
      inflight_d = 1'b0;

      active   = (state_q == S_FETCH) || (state_q == S_DRAIN);
      // The pending read is counted as occupied so a word already on its way
      // from SRAM always has a FIFO slot waiting for it.
      rd_issue = (state_q == S_FETCH) && (issued_q < len_q) &&
                 ((occ_q + {4'b0, inflight_q}) < OCC_MAX);

      sram_cen  = ~rd_issue;
      sram_addr = (state_q == S_FETCH) ? (base_q + aw'(issued_q)) : '0;
      fifo_in   = sram_rdata;
      // SRAM data lands exactly one cycle after the read, so the pending-read
      // flag doubles as the write strobe.
      fifo_wr   = inflight_q;
      fifo_rd   = active && fifo_ready && dn_ready && (drained_q < len_q);
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);

      if (rd_issue) begin
         issued_d   = issued_q + cw'(1);
         inflight_d = 1'b1;
      end
      if (fifo_wr) begin
         written_d = written_q + cw'(1);
      end
      if (fifo_rd) begin
         drained_d = drained_q + cw'(1);
      end
      case ({fifo_wr, fifo_rd})
         2'b10:   occ_d = occ_q + 5'd1;
         2'b01:   occ_d = occ_q - 5'd1;
         default: occ_d = occ_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d    = base_addr;
               len_d     = len;
               issued_d  = '0;
               written_d = '0;
               drained_d = '0;
               state_d   = (len == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            // written trails issued by the pending read, so written == len
            // means every read is issued and none is still in flight.
            if (written_q == len_q) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Uses the next-state count so a final pop this cycle finishes.
            if (drained_d == len_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef IFIFO_CTRL_PERF_EN
   // A cycle is starved when the array wants data, the FIFO is empty and
   // words are still owed; once all words are delivered it is not a stall.
   always_comb begin
      stall_d = stall_q;
      if ((state_q == S_IDLE) && start) begin
         stall_d = '0;
      end else if (active && dn_ready && !fifo_ready && (drained_q < len_q) &&
                   (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         written_q  <= '0;
         drained_q  <= '0;
         occ_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         written_q  <= written_d;
         drained_q  <= drained_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
      end
   end

   // Occupancy gating must keep writes away from a full FIFO.
   always_ff @(posedge clk) begin
      if (reset) begin
         no_write_when_full: assert (!(fifo_wr && fifo_full));
      end
   end

endmodule

// File: tb/tb_ififo_ctrl.sv
// tb/tb_ififo_ctrl.sv - directed self-checking bench for ififo_ctrl

module tb_ififo_ctrl;

   localparam int AW = 11;
   localparam int CW = 11;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [CW-1:0] len;
   logic          sram_cen;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_rdata = '0;
   logic [DW-1:0] fifo_in;
   logic          fifo_wr;
   logic          fifo_full;
   logic          fifo_ready;
   logic          fifo_rd;
   logic          dn_ready;
   logic          busy;
   logic          done;
`ifdef IFIFO_CTRL_PERF_EN
   logic [15:0]   stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ififo_ctrl #(.bw(4), .row(8), .aw(AW), .cw(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .len        (len),
      .sram_cen   (sram_cen),
      .sram_addr  (sram_addr),
      .sram_rdata (sram_rdata),
      .fifo_in    (fifo_in),
      .fifo_wr    (fifo_wr),
      .fifo_full  (fifo_full),
      .fifo_ready (fifo_ready),
      .fifo_rd    (fifo_rd),
      .dn_ready   (dn_ready),
      .busy       (busy),
      .done       (done)
`ifdef IFIFO_CTRL_PERF_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {a, 10'h2A5, ~a};
   endfunction

   // SRAM: one-cycle read latency
   always @(posedge clk) begin
      if (!sram_cen) sram_rdata <= mem_word(sram_addr);
   end

   // 16-entry FIFO
   logic [DW-1:0] fifo_q[$];
   int            fifo_cnt = 0;
   always @(posedge clk) begin
      if (!reset) begin
         fifo_q.delete();
      end else begin
         if (fifo_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
         if (fifo_wr) fifo_q.push_back(fifo_in);
      end
      fifo_cnt <= fifo_q.size();
   end
   assign fifo_ready = (fifo_cnt != 0);
   assign fifo_full  = (fifo_cnt >= 16);

   // per-transfer records
   logic [AW-1:0] rd_addr[64];
   int            rd_cyc[64];
   int            wr_cyc[64];
   int            pop_cyc[64];
   logic [DW-1:0] pop_data[64];
   int            n_rd, n_wr, n_pop, n_done, done_cyc, first_pop, wr_before_pop;
   logic          wr_full_hit, busy_after;
   logic [15:0]   stall_at_done;

   task automatic sample(input int c);
      if (!sram_cen && n_rd < 64) begin
         rd_addr[n_rd] = sram_addr;
         rd_cyc[n_rd]  = c;
         n_rd++;
      end
      if (fifo_wr && n_wr < 64) begin
         wr_cyc[n_wr] = c;
         n_wr++;
         if (fifo_full) wr_full_hit = 1'b1;
         if (first_pop < 0) wr_before_pop++;
      end
      if (fifo_rd && n_pop < 64) begin
         pop_data[n_pop] = (fifo_q.size() > 0) ? fifo_q[0] : 'x;
         pop_cyc[n_pop]  = c;
         n_pop++;
         if (first_pop < 0) first_pop = c;
      end
      if (done) begin
         n_done++;
         done_cyc = c;
`ifdef IFIFO_CTRL_PERF_EN
         stall_at_done = stall_cnt;
`endif
      end
   endtask

   // Cycle 0 is the start cycle; dn_ready rises at cycle dn_on; a second
   // start with junk base/len is pulsed at cycle ign_at (when > 0).
   task automatic run_xfer(input logic [AW-1:0] b, input logic [CW-1:0] n,
                           input int dn_on, input int ign_at, input int maxc);
      n_rd = 0; n_wr = 0; n_pop = 0; n_done = 0; done_cyc = -1;
      first_pop = -1; wr_before_pop = 0; wr_full_hit = 1'b0;
      busy_after = 1'bx; stall_at_done = '0;
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; len = n; dn_ready = (dn_on <= 0);
      #1;
      sample(0);
      for (int c = 1; c <= maxc; c++) begin
         @(posedge clk); #1;
         start = (c == ign_at); base_addr = 11'h555; len = 11'd7;
         dn_ready = (c >= dn_on);
         #1;
         sample(c);
         if (done_cyc >= 0 && c == done_cyc + 1) begin
            busy_after = busy;
            break;
         end
      end
      start = 1'b0;
      if (done_cyc < 0) begin
         failures++; checks++;
         $display("FAIL xfer_timeout: no done within %0d cycles", maxc);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; base_addr = '0; len = '0; dn_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checks++; if (sram_cen !== 1'b1) begin failures++; $display("FAIL reset_cen: got %b want 1", sram_cen); end
      checks++; if (sram_addr !== 11'h000) begin failures++; $display("FAIL reset_addr: got %h want 000", sram_addr); end
      checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL reset_wr: got %b want 0", fifo_wr); end
      checks++; if (fifo_rd !== 1'b0) begin failures++; $display("FAIL reset_rd: got %b want 0", fifo_rd); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
`ifdef IFIFO_CTRL_PERF_EN
      checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL reset_stall: got %h want 0", stall_cnt); end
`endif
      reset = 1'b1;
   endtask

   task automatic test_basic();
      logic [AW-1:0] ea;
      run_xfer(11'h010, 11'd4, 0, -1, 40);
      checks++; if (n_rd !== 4) begin failures++; $display("FAIL basic_nrd: got %0d want 4", n_rd); end
      checks++; if (n_wr !== 4) begin failures++; $display("FAIL basic_nwr: got %0d want 4", n_wr); end
      checks++; if (n_pop !== 4) begin failures++; $display("FAIL basic_npop: got %0d want 4", n_pop); end
      for (int k = 0; k < 4; k++) begin
         ea = 11'h010 + AW'(k);
         checks++; if (rd_addr[k] !== ea || rd_cyc[k] !== k + 1) begin
            failures++; $display("FAIL basic_rd%0d: got %h@%0d want %h@%0d", k, rd_addr[k], rd_cyc[k], ea, k + 1); end
         checks++; if (wr_cyc[k] !== k + 2) begin
            failures++; $display("FAIL basic_wr%0d: got cycle %0d want %0d", k, wr_cyc[k], k + 2); end
         checks++; if (pop_data[k] !== mem_word(ea)) begin
            failures++; $display("FAIL basic_pop%0d: got %h want %h", k, pop_data[k], mem_word(ea)); end
      end
      checks++; if (pop_cyc[0] !== 3) begin failures++; $display("FAIL basic_first_pop: got %0d want 3", pop_cyc[0]); end
      checks++; if (n_done !== 1 || done_cyc !== 8) begin failures++; $display("FAIL basic_done: got %0d@%0d want 1@8", n_done, done_cyc); end
      checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b want 0", busy_after); end
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] ea;
      int bad = 0;
      run_xfer(11'h040, 11'd20, 30, -1, 100);
      checks++; if (wr_before_pop !== 15) begin failures++; $display("FAIL bp_prefill: got %0d want 15", wr_before_pop); end
      checks++; if (first_pop !== 30) begin failures++; $display("FAIL bp_first_pop: got %0d want 30", first_pop); end
      checks++; if (wr_full_hit !== 1'b0) begin failures++; $display("FAIL bp_wr_full: got %b want 0", wr_full_hit); end
      checks++; if (n_rd !== 20 || n_pop !== 20) begin failures++; $display("FAIL bp_counts: got rd=%0d pop=%0d want 20", n_rd, n_pop); end
      for (int k = 0; k < 20; k++) begin
         ea = 11'h040 + AW'(k);
         if (pop_data[k] !== mem_word(ea)) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL bp_order: got %0d bad words want 0", bad); end
      checks++; if (n_done !== 1) begin failures++; $display("FAIL bp_done: got %0d want 1", n_done); end
   endtask

   task automatic test_zero_len();
      run_xfer(11'h123, 11'd0, 0, -1, 10);
      checks++; if (done_cyc !== 1) begin failures++; $display("FAIL zero_done: got %0d want 1", done_cyc); end
      checks++; if (n_rd !== 0 || n_wr !== 0 || n_pop !== 0) begin
         failures++; $display("FAIL zero_activity: got rd=%0d wr=%0d pop=%0d want 0", n_rd, n_wr, n_pop); end
      checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL zero_busy_after: got %b want 0", busy_after); end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_a[4];
      exp_a[0] = 11'h7FE; exp_a[1] = 11'h7FF; exp_a[2] = 11'h000; exp_a[3] = 11'h001;
      run_xfer(11'h7FE, 11'd4, 0, -1, 40);
      checks++; if (n_rd !== 4) begin failures++; $display("FAIL wrap_nrd: got %0d want 4", n_rd); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (rd_addr[k] !== exp_a[k]) begin
            failures++; $display("FAIL wrap_addr%0d: got %h want %h", k, rd_addr[k], exp_a[k]); end
      end
   endtask

   task automatic test_mid_reset();
      logic [AW-1:0] ea;
      int seen_done = 0;
      @(posedge clk); #1;
      start = 1'b1; base_addr = 11'h100; len = 11'd10; dn_ready = 1'b1;
      #1;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (c == 6) reset = 1'b0;
         #1;
         if (done) seen_done++;
      end
      @(posedge clk); #2;
      checks++; if (sram_cen !== 1'b1 || sram_addr !== 11'h000) begin
         failures++; $display("FAIL mreset_sram: got cen=%b addr=%h want 1/000", sram_cen, sram_addr); end
      checks++; if (fifo_wr !== 1'b0 || fifo_rd !== 1'b0) begin
         failures++; $display("FAIL mreset_fifo: got wr=%b rd=%b want 0/0", fifo_wr, fifo_rd); end
      checks++; if (busy !== 1'b0 || done !== 1'b0 || seen_done !== 0) begin
         failures++; $display("FAIL mreset_status: got busy=%b done=%b seen=%0d want 0", busy, done, seen_done); end
`ifdef IFIFO_CTRL_PERF_EN
      checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL mreset_stall: got %h want 0", stall_cnt); end
`endif
      reset = 1'b1;
      run_xfer(11'h020, 11'd3, 0, -1, 30);
      checks++; if (done_cyc !== 7 || n_rd !== 3 || n_pop !== 3) begin
         failures++; $display("FAIL mreset_fresh: got done@%0d rd=%0d pop=%0d want 7/3/3", done_cyc, n_rd, n_pop); end
      for (int k = 0; k < 3; k++) begin
         ea = 11'h020 + AW'(k);
         checks++; if (pop_data[k] !== mem_word(ea)) begin
            failures++; $display("FAIL mreset_pop%0d: got %h want %h", k, pop_data[k], mem_word(ea)); end
      end
   endtask

   task automatic test_start_ignored();
      run_xfer(11'h200, 11'd2, 0, 2, 30);
      checks++; if (n_rd !== 2 || rd_addr[0] !== 11'h200 || rd_addr[1] !== 11'h201) begin
         failures++; $display("FAIL ign_reads: got n=%0d %h %h want 2 200 201", n_rd, rd_addr[0], rd_addr[1]); end
      checks++; if (done_cyc !== 6 || n_pop !== 2) begin
         failures++; $display("FAIL ign_done: got done@%0d pop=%0d want 6/2", done_cyc, n_pop); end
      checks++; if (pop_data[1] !== mem_word(11'h201)) begin
         failures++; $display("FAIL ign_data: got %h want %h", pop_data[1], mem_word(11'h201)); end
`ifdef IFIFO_CTRL_PERF_EN
      checks++; if (stall_at_done !== 16'd2) begin failures++; $display("FAIL ign_stall: got %0d want 2", stall_at_done); end
`endif
   endtask

   task automatic test_back_to_back();
      run_xfer(11'h300, 11'd2, 0, -1, 30);
      checks++; if (done_cyc !== 6 || n_rd !== 2 || rd_addr[0] !== 11'h300) begin
         failures++; $display("FAIL b2b_xfer: got done@%0d rd=%0d a0=%h want 6/2/300", done_cyc, n_rd, rd_addr[0]); end
`ifdef IFIFO_CTRL_PERF_EN
      checks++; if (stall_at_done !== 16'd2) begin failures++; $display("FAIL b2b_stall: got %0d want 2", stall_at_done); end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_len();
      test_wrap();
      test_mid_reset();
      test_start_ignored();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
